// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DIV_STOP = div_t'(0);
  localparam div_t DIV_MIN  = div_t'(2);

  function automatic div_t half(input div_t d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/pending divisor, registered output.
// Optional CLK_DIV_ODD_DUTY50_EN adds a negedge flop for 50% duty at odd N.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DIV_W,
  parameter int unsigned RST_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] val,
  output logic             pend,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_D = CNT_W'(RST_DIV);
  localparam logic [CNT_W-1:0] STOP  = CNT_W'(DIV_STOP);

  logic [CNT_W-1:0] cnt, div, pval;
  logic [CNT_W-1:0] cnt_n, div_n, pval_n;
  logic             q, q_n, pend_n;
  logic             running, wrap, restart;

  assign running = (div != STOP);
  assign wrap    = running && (cnt == div - ONE);

  always_comb begin
    div_n   = div;
    pval_n  = pval;
    pend_n  = pend;
    cnt_n   = cnt;
    q_n     = q;
    restart = 1'b0;
    if (running) begin
      // sync consumes the previously pending value; a same-cycle load queues behind it
      if (pend && (wrap || sync)) begin
        div_n   = pval;
        pend_n  = 1'b0;
        restart = 1'b1;
      end else if (sync) begin
        restart = 1'b1;
      end
      if (ld) begin
        pval_n = val;
        pend_n = 1'b1;
      end
    end else begin
      // a stopped channel has no period boundary to wait for
      if (ld) begin
        div_n   = val;
        pend_n  = 1'b0;
        restart = 1'b1;
      end else if (pend) begin
        div_n   = pval;
        pend_n  = 1'b0;
        restart = 1'b1;
      end
    end

    if (div_n == STOP) begin
      cnt_n = '0;
      q_n   = 1'b0;
    end else if (restart) begin
      cnt_n = '0;
      q_n   = 1'b1;
    end else begin
      cnt_n = wrap ? '0 : cnt + ONE;
      q_n   = (cnt_n < (div >> 1));
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div  <= RST_D;
      cnt  <= RST_D - ONE;
      pval <= '0;
      pend <= 1'b0;
      q    <= 1'b0;
    end else begin
      div  <= div_n;
      cnt  <= cnt_n;
      pval <= pval_n;
      pend <= pend_n;
      q    <= q_n;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic qn;

  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) qn <= 1'b0;
    else      qn <= q;
  end

  // q and qn are both low across every period boundary, so the div[0] select cannot glitch
  assign clk_out = div[0] ? (q | qn) : q;
`else
  assign clk_out = q;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable integer clock divider; decodes divisor loads
// and instantiates one clk_div_ch per channel.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 3,
  parameter  int unsigned CNT_W   = 8,
  parameter  int unsigned RST_DIV = 2,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sync,
  input  logic              div_ld,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] div_pend,
  output logic [NUM_CH-1:0] clk_out
);

  logic [CNT_W-1:0] val_c;

  assign val_c = (div_val == CNT_W'(1)) ? CNT_W'(DIV_MIN) : div_val;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ld_g;

    // out-of-range channel numbers match no instance and are dropped
    assign ld_g = div_ld && (div_ch == CH_W'(g));

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .sync    (sync),
      .ld      (ld_g),
      .val     (val_c),
      .pend    (div_pend[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule
